// File: rtl/id_stage_if.sv
// id_stage_if: valid/allowin handshake carrying one pipeline bus between two stages.
// The producing stage uses the master modport and the consuming stage uses the slave modport.
interface id_stage_if #(
   parameter int WD = 64
);
   logic          valid;
   logic [WD-1:0] bus;
   logic          allowin;

   modport master (output valid, output bus, input allowin);
   modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/id_stage.sv
// id_stage: LA32R decode stage. Latches {inst, pc} from fetch, decodes an integer
// subset, reads the register file with ES/MS/WS forwarding, interlocks on load-use,
// resolves branches back to fetch and emits the packed operation bus to execute.
module id_stage #(
   parameter int FS_TO_DS_BUS_WD = 64,
   parameter int DS_TO_ES_BUS_WD = 148,
   parameter int BR_BUS_WD       = 33
) (
   input  logic                 clk,
   input  logic                 reset,
   id_stage_if.slave            fs_ds,
   id_stage_if.master           ds_es,
   output logic [BR_BUS_WD-1:0] br_bus,
   output logic [4:0]           rf_raddr1,
   input  logic [31:0]          rf_rdata1,
   output logic [4:0]           rf_raddr2,
   input  logic [31:0]          rf_rdata2,
   input  logic [38:0]          es_fwd_bus,
   input  logic [37:0]          ms_fwd_bus,
   input  logic [37:0]          ws_fwd_bus
);
   localparam logic [11:0] ALU_ADD = 12'b1000_0000_0000;
   localparam logic [11:0] ALU_LUI = 12'b0000_0000_0001;

   // Forwarded register value: r0 is hard zero, then ES (non-load), MS, WS, regfile.
   function automatic logic [31:0] fwd_value(input logic [4:0]  addr,
                                             input logic [31:0] rf_val,
                                             input logic [38:0] es,
                                             input logic [37:0] ms,
                                             input logic [37:0] ws);
      logic [31:0] v;
      if (addr == 5'd0) begin
         v = 32'd0;
      end else if (es[38] && !es[37] && (es[36:32] == addr)) begin
         v = es[31:0];
      end else if (ms[37] && (ms[36:32] == addr)) begin
         v = ms[31:0];
      end else if (ws[37] && (ws[36:32] == addr)) begin
         v = ws[31:0];
      end else begin
         v = rf_val;
      end
      return v;
   endfunction

   logic                       ds_valid_q, ds_valid_d;
   logic [31:0]                ds_inst_q, ds_inst_d;
   logic [31:0]                ds_pc_q, ds_pc_d;
   logic [FS_TO_DS_BUS_WD-1:0] fs_bus;
   logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;

   logic [4:0]  rd, rj, rk;
   logic [11:0] si12;
   logic [19:0] si20;
   logic [15:0] offs16;
   logic [25:0] offs26;
   logic [16:0] op17;
   logic [9:0]  op10;
   logic [6:0]  op7;
   logic [5:0]  op6;

   logic inst_add, inst_sub, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
   logic inst_slli, inst_srli, inst_srai, inst_addi, inst_lu12i, inst_ld, inst_st;
   logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne, inst_3r, inst_shift;

   logic [11:0] alu_op;
   logic        use1, use2, r2_is_rd, gr_we, mem_we, load_op, src1_is_pc, src2_is_imm;
   logic [31:0] imm;
   logic [4:0]  dest;
   logic [31:0] rj_value, rkd_value, alu_src1, alu_src2, br_target;
   logic        es_we, es_is_load, load_use_stall, ds_ready_go, ds_allowin;
   logic        br_cond, br_taken;
   logic [4:0]  es_dest;

   assign fs_bus = fs_ds.bus;

   assign rd     = ds_inst_q[4:0];
   assign rj     = ds_inst_q[9:5];
   assign rk     = ds_inst_q[14:10];
   assign si12   = ds_inst_q[21:10];
   assign si20   = ds_inst_q[24:5];
   assign offs16 = ds_inst_q[25:10];
   assign offs26 = {ds_inst_q[9:0], ds_inst_q[25:10]};
   assign op17   = ds_inst_q[31:15];
   assign op10   = ds_inst_q[31:22];
   assign op7    = ds_inst_q[31:25];
   assign op6    = ds_inst_q[31:26];

   assign inst_add   = (op17 == 17'h00020);
   assign inst_sub   = (op17 == 17'h00022);
   assign inst_slt   = (op17 == 17'h00024);
   assign inst_sltu  = (op17 == 17'h00025);
   assign inst_nor   = (op17 == 17'h00028);
   assign inst_and   = (op17 == 17'h00029);
   assign inst_or    = (op17 == 17'h0002a);
   assign inst_xor   = (op17 == 17'h0002b);
   assign inst_slli  = (op17 == 17'h00081);
   assign inst_srli  = (op17 == 17'h00089);
   assign inst_srai  = (op17 == 17'h00091);
   assign inst_addi  = (op10 == 10'h00a);
   assign inst_ld    = (op10 == 10'h0a2);
   assign inst_st    = (op10 == 10'h0a6);
   assign inst_lu12i = (op7  == 7'h0a);
   assign inst_jirl  = (op6  == 6'h13);
   assign inst_b     = (op6  == 6'h14);
   assign inst_bl    = (op6  == 6'h15);
   assign inst_beq   = (op6  == 6'h16);
   assign inst_bne   = (op6  == 6'h17);

   assign inst_3r    = inst_add | inst_sub | inst_slt | inst_sltu |
                       inst_and | inst_or  | inst_nor | inst_xor;
   assign inst_shift = inst_slli | inst_srli | inst_srai;

   // Per-instruction control: ALU op, which sources are read, write enables, immediate.
   always_comb begin
      alu_op      = 12'd0;
      use1        = 1'b0;
      use2        = 1'b0;
      r2_is_rd    = 1'b0;
      gr_we       = 1'b0;
      mem_we      = 1'b0;
      load_op     = 1'b0;
      src1_is_pc  = 1'b0;
      src2_is_imm = 1'b0;
      imm         = 32'd0;
      if (inst_3r) begin
         alu_op = {inst_add, inst_sub, inst_slt, inst_sltu,
                   inst_and, inst_nor, inst_or, inst_xor, 4'b0000};
         use1   = 1'b1;
         use2   = 1'b1;
         gr_we  = 1'b1;
      end else if (inst_shift) begin
         alu_op      = {8'b0000_0000, inst_slli, inst_srli, inst_srai, 1'b0};
         use1        = 1'b1;
         gr_we       = 1'b1;
         src2_is_imm = 1'b1;
         imm         = {27'd0, rk};
      end else if (inst_addi | inst_ld | inst_st) begin
         alu_op      = ALU_ADD;
         use1        = 1'b1;
         use2        = inst_st;
         r2_is_rd    = inst_st;
         gr_we       = !inst_st;
         mem_we      = inst_st;
         load_op     = inst_ld;
         src2_is_imm = 1'b1;
         imm         = {{20{si12[11]}}, si12};
      end else if (inst_lu12i) begin
         alu_op      = ALU_LUI;
         gr_we       = 1'b1;
         src2_is_imm = 1'b1;
         imm         = {si20, 12'd0};
      end else if (inst_jirl | inst_bl) begin
         alu_op      = ALU_ADD;
         use1        = inst_jirl;
         gr_we       = 1'b1;
         src1_is_pc  = 1'b1;
         src2_is_imm = 1'b1;
         imm         = 32'd4;
      end else if (inst_beq | inst_bne) begin
         use1     = 1'b1;
         use2     = 1'b1;
         r2_is_rd = 1'b1;
      end else begin
         // b and unrecognised encodings write nothing and read nothing
         alu_op = 12'd0;
      end
   end

   assign rf_raddr1 = rj;
   assign rf_raddr2 = r2_is_rd ? rd : rk;
   assign rj_value  = fwd_value(rj, rf_rdata1, es_fwd_bus, ms_fwd_bus, ws_fwd_bus);
   assign rkd_value = fwd_value(rf_raddr2, rf_rdata2, es_fwd_bus, ms_fwd_bus, ws_fwd_bus);
   assign dest      = inst_bl ? 5'd1 : rd;
   assign alu_src1  = src1_is_pc ? ds_pc_q : rj_value;
   assign alu_src2  = src2_is_imm ? imm : rkd_value;

   // A load still in ES cannot forward yet, so any used source matching it must wait.
   assign es_we          = es_fwd_bus[38];
   assign es_is_load     = es_fwd_bus[37];
   assign es_dest        = es_fwd_bus[36:32];
   assign load_use_stall = ds_valid_q && es_we && es_is_load && (es_dest != 5'd0) &&
                           ((use1 && (es_dest == rj)) || (use2 && (es_dest == rf_raddr2)));
   assign ds_ready_go    = !load_use_stall;
   assign ds_allowin     = !ds_valid_q || (ds_ready_go && ds_es.allowin);
   assign fs_ds.allowin  = ds_allowin;
   assign ds_es.valid    = ds_valid_q && ds_ready_go;

   // Branches resolve only when the instruction actually moves on to execute.
   assign br_cond   = inst_b | inst_bl | inst_jirl |
                      (inst_beq && (rj_value == rkd_value)) |
                      (inst_bne && (rj_value != rkd_value));
   assign br_taken  = ds_valid_q && ds_ready_go && ds_es.allowin && br_cond;
   assign br_target = inst_jirl          ? rj_value + {{14{offs16[15]}}, offs16, 2'b00} :
                      (inst_b | inst_bl) ? ds_pc_q  + {{4{offs26[25]}}, offs26, 2'b00}  :
                                           ds_pc_q  + {{14{offs16[15]}}, offs16, 2'b00};
   assign br_bus    = br_taken ? {1'b1, br_target} : {BR_BUS_WD{1'b0}};

   assign ds_to_es_bus = {alu_op, load_op, mem_we, gr_we, dest,
                          alu_src1, alu_src2, rkd_value, ds_pc_q};
   assign ds_es.bus    = ds_to_es_bus;

   // Next decode-slot contents: accept from fetch when allowed, dropping the wrong path.
   always_comb begin
      ds_valid_d = ds_valid_q;
      ds_inst_d  = ds_inst_q;
      ds_pc_d    = ds_pc_q;
      if (ds_allowin) begin
         ds_valid_d = fs_ds.valid && !br_taken;
         ds_inst_d  = fs_bus[63:32];
         ds_pc_d    = fs_bus[31:0];
      end else begin
         ds_valid_d = ds_valid_q;
      end
   end

   // Decode-slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         ds_valid_q <= 1'b0;
         ds_inst_q  <= 32'd0;
         ds_pc_q    <= 32'd0;
      end else begin
         ds_valid_q <= ds_valid_d;
         ds_inst_q  <= ds_inst_d;
         ds_pc_q    <= ds_pc_d;
      end
   end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for the decode stage. Expected decode results are
// queued as each instruction is sent and compared whenever the stage hands off to ES.
module tb_id_stage;
   localparam logic [11:0] OP_ADD = 12'h800;
   localparam logic [11:0] OP_SRA = 12'h002;
   localparam logic [11:0] OP_LUI = 12'h001;

   typedef struct packed {
      logic        full;
      logic [11:0] alu_op;
      logic        load_op;
      logic        mem_we;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] rkd;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [32:0] br_bus;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [38:0] es_fwd_bus;
   logic [37:0] ms_fwd_bus, ws_fwd_bus;
   logic [31:0] rf [32];
   exp_t        exp_q [$];
   exp_t        sb_e;
   int          n_checks = 0;
   int          n_errors = 0;

   id_stage_if #(.WD(64))  fs_ds ();
   id_stage_if #(.WD(148)) ds_es ();

   id_stage dut (
      .clk        (clk),
      .reset      (reset),
      .fs_ds      (fs_ds),
      .ds_es      (ds_es),
      .br_bus     (br_bus),
      .rf_raddr1  (rf_raddr1),
      .rf_rdata1  (rf_rdata1),
      .rf_raddr2  (rf_raddr2),
      .rf_rdata2  (rf_rdata2),
      .es_fwd_bus (es_fwd_bus),
      .ms_fwd_bus (ms_fwd_bus),
      .ws_fwd_bus (ws_fwd_bus)
   );

   always #5 clk = ~clk;

   assign rf_rdata1 = rf[rf_raddr1];
   assign rf_rdata2 = rf[rf_raddr2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input logic full, input logic [11:0] alu, input logic ld,
                          input logic mw, input logic gw, input logic [4:0] dst,
                          input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] rkd, input logic [31:0] pc);
      exp_t e;
      e = '{full, alu, ld, mw, gw, dst, s1, s2, rkd, pc};
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch beat: instruction sits in decode when this returns, fetch idle.
   task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
      fs_ds.valid = 1'b1;
      fs_ds.bus   = {inst, pc};
      tick();
      fs_ds.valid = 1'b0;
      #1;
   endtask

   // Scoreboard: compare every hand-off to execute against the oldest expectation.
   always @(negedge clk) begin
      if (!reset && ds_es.valid && ds_es.allowin) begin
         check_eq("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            sb_e = exp_q.pop_front();
            check_eq("sb_pc",     ds_es.bus[31:0], sb_e.pc);
            check_eq("sb_gr_we",  ds_es.bus[133],  sb_e.gr_we);
            check_eq("sb_mem_we", ds_es.bus[134],  sb_e.mem_we);
            if (sb_e.full) begin
               check_eq("sb_alu_op",  ds_es.bus[147:136], sb_e.alu_op);
               check_eq("sb_load_op", ds_es.bus[135],     sb_e.load_op);
               check_eq("sb_dest",    ds_es.bus[132:128], sb_e.dest);
               check_eq("sb_src1",    ds_es.bus[127:96],  sb_e.src1);
               check_eq("sb_src2",    ds_es.bus[95:64],   sb_e.src2);
               check_eq("sb_rkd",     ds_es.bus[63:32],   sb_e.rkd);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      reset          = 1'b1;
      fs_ds.valid    = 1'b0;
      fs_ds.bus      = 64'd0;
      ds_es.allowin  = 1'b1;
      es_fwd_bus     = 39'd0;
      ms_fwd_bus     = 38'd0;
      ws_fwd_bus     = 38'd0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      check_eq("rst_allowin", fs_ds.allowin, 1'b1);
      check_eq("rst_valid",   ds_es.valid,   1'b0);
      check_eq("rst_br_bus",  br_bus,        33'd0);

      // plain add.w r3,r1,r2
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rf[5] = 32'h1c000200;
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 32'd5, 32'd7, 32'd7, 32'h1c000000);
      issue(32'h00100823, 32'h1c000000);
      check_eq("add_valid", ds_es.valid, 1'b1);
      tick();

      // ES beats WS on rj, MS supplies rk
      es_fwd_bus = {1'b1, 1'b0, 5'd1, 32'h10};
      ms_fwd_bus = {1'b1, 5'd2, 32'h20};
      ws_fwd_bus = {1'b1, 5'd1, 32'h30};
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 32'h10, 32'h20, 32'h20, 32'h1c000004);
      issue(32'h00100823, 32'h1c000004);
      tick();

      // MS beats WS on rj, WS supplies rk, non-matching ES ignored
      es_fwd_bus = {1'b1, 1'b0, 5'd3, 32'h99};
      ms_fwd_bus = {1'b1, 5'd1, 32'h21};
      ws_fwd_bus = {1'b1, 5'd2, 32'h30};
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 32'h21, 32'h30, 32'h30, 32'h1c000008);
      issue(32'h00100823, 32'h1c000008);
      tick();

      // r0 source: never forwarded, never stalled on
      es_fwd_bus = {1'b1, 1'b1, 5'd0, 32'hdead};
      ms_fwd_bus = {1'b1, 5'd0, 32'hbeef};
      ws_fwd_bus = 38'd0;
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'd7, 32'd7, 32'h1c00000c);
      issue(32'h00100803, 32'h1c00000c);
      check_eq("r0_no_stall", ds_es.valid, 1'b1);
      tick();

      // load-use on rj: held, then issues with the MS value
      es_fwd_bus = {1'b1, 1'b1, 5'd1, 32'hbad};
      ms_fwd_bus = {1'b1, 5'd1, 32'h55};
      issue(32'h00100823, 32'h1c000010);
      for (int k = 0; k < 3; k++) begin
         check_eq("lu_valid",   ds_es.valid,   1'b0);
         check_eq("lu_allowin", fs_ds.allowin, 1'b0);
         tick();
      end
      es_fwd_bus = 39'd0;
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55, 32'd7, 32'd7, 32'h1c000010);
      #1;
      check_eq("lu_release", ds_es.valid, 1'b1);
      tick();
      ms_fwd_bus = 38'd0;

      // lu12i.w r4,0x12345: rj field matches the load but is not a used source
      es_fwd_bus = {1'b1, 1'b1, 5'd5, 32'h0};
      sb_push(1'b1, OP_LUI, 1'b0, 1'b0, 1'b1, 5'd4, 32'h1c000200, 32'h12345000, 32'd0, 32'h1c000014);
      issue(32'h142468a4, 32'h1c000014);
      check_eq("lui_no_stall", ds_es.valid, 1'b1);
      tick();
      es_fwd_bus = 39'd0;

      // srai.w r6,r1,3
      sb_push(1'b1, OP_SRA, 1'b0, 1'b0, 1'b1, 5'd6, 32'd5, 32'd3, 32'd0, 32'h1c000018);
      issue(32'h00488c26, 32'h1c000018);
      tick();

      // st.w r2,r1,-4: second read port uses rd, negative offset sign-extends
      sb_push(1'b1, OP_ADD, 1'b0, 1'b1, 1'b0, 5'd2, 32'd5, 32'hfffffffc, 32'd7, 32'h1c00001c);
      issue(32'h29bff022, 32'h1c00001c);
      check_eq("st_raddr2", rf_raddr2, 5'd2);
      tick();

      // unknown encoding passes down as a NOP
      sb_push(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h1c000020);
      issue(32'hffffffff, 32'h1c000020);
      check_eq("nop_valid",  ds_es.valid, 1'b1);
      check_eq("nop_br_bus", br_bus,      33'd0);
      tick();

      // beq taken, fall-through dropped
      rf[1] = 32'd9;
      rf[2] = 32'd9;
      sb_push(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h1c000010);
      issue(32'h58000822, 32'h1c000010);
      fs_ds.valid = 1'b1;
      fs_ds.bus   = {32'h00100823, 32'h1c000014};
      #1;
      check_eq("beq_br_bus",  br_bus,        {1'b1, 32'h1c000018});
      check_eq("beq_allowin", fs_ds.allowin, 1'b1);
      tick();
      fs_ds.valid = 1'b0;
      #1;
      check_eq("beq_drop",    ds_es.valid, 1'b0);
      check_eq("beq_br_idle", br_bus,      33'd0);

      // beq not taken
      rf[2] = 32'd8;
      sb_push(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h1c000018);
      issue(32'h58000822, 32'h1c000018);
      check_eq("beq_nt", br_bus[32], 1'b0);
      tick();

      // bne taken
      sb_push(1'b0, 12'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h1c000020);
      issue(32'h5c000822, 32'h1c000020);
      check_eq("bne_br_bus", br_bus, {1'b1, 32'h1c000028});
      tick();

      // bl held by execute back-pressure, then taken
      ds_es.allowin = 1'b0;
      issue(32'h54004000, 32'h1c000100);
      for (int k = 0; k < 2; k++) begin
         check_eq("bl_hold_br",      br_bus[32],           1'b0);
         check_eq("bl_hold_allowin", fs_ds.allowin,        1'b0);
         check_eq("bl_hold_dest",    ds_es.bus[132:128],   5'd1);
         check_eq("bl_hold_src1",    ds_es.bus[127:96],    32'h1c000100);
         tick();
      end
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1c000100, 32'd4, 32'd0, 32'h1c000100);
      ds_es.allowin = 1'b1;
      #1;
      check_eq("bl_br_bus", br_bus, {1'b1, 32'h1c000140});
      tick();

      // jirl r1,r5,16: target from the register, link = pc+4
      sb_push(1'b1, OP_ADD, 1'b0, 1'b0, 1'b1, 5'd1, 32'h1c000030, 32'd4, 32'd0, 32'h1c000030);
      issue(32'h4c0010a1, 32'h1c000030);
      check_eq("jirl_br_bus", br_bus, {1'b1, 32'h1c000210});
      tick();

      // reset during a load-use stall discards the held instruction
      es_fwd_bus = {1'b1, 1'b1, 5'd1, 32'h0};
      issue(32'h00100823, 32'h1c000040);
      check_eq("rst_stall_pre", ds_es.valid, 1'b0);
      reset = 1'b1;
      tick();
      reset      = 1'b0;
      es_fwd_bus = 39'd0;
      #1;
      check_eq("rst_stall_valid",   ds_es.valid,   1'b0);
      check_eq("rst_stall_allowin", fs_ds.allowin, 1'b1);
      check_eq("rst_stall_br",      br_bus,        33'd0);
      tick();

      check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage LA32R pipeline; sits directly downstream of the fetch stage.
- Latches {inst, pc} from fetch, decodes a fixed integer subset and reads the register file with ES/MS/WS forwarding.
- Interlocks on load-use hazards, resolves branches (br_bus back to fetch) and hands a packed operation bus to the execute stage.
- Drops the wrong-path instruction that fetch delivers in the cycle a branch is taken.

Parameters:
FS_TO_DS_BUS_WD, 64, {inst[63:32], pc[31:0]}
DS_TO_ES_BUS_WD, 148, decoded bus (layout in Behaviour)
BR_BUS_WD, 33, {br_taken, br_target[31:0]}

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
es_allowin  in  1  execute stage can accept
ds_allowin  out  1  decode can accept from fetch
fs_to_ds_valid  in  1  fetch bus valid
fs_to_ds_bus  in  64  {inst, pc}
ds_to_es_valid  out  1  decode bus valid
ds_to_es_bus  out  148  decoded operation
br_bus  out  33  {br_taken, br_target} to fetch
rf_raddr1  out  5  regfile read addr (rj)
rf_rdata1  in  32  regfile read data 1
rf_raddr2  out  5  regfile read addr (rk or rd)
rf_rdata2  in  32  regfile read data 2
es_fwd_bus  in  39  {es_we, es_is_load, es_dest[4:0], es_value[31:0]}; es_we already qualified by es_valid
ms_fwd_bus  in  38  {ms_we, ms_dest, ms_value}
ws_fwd_bus  in  38  {ws_we, ws_dest, ws_value}

Behaviour:
- Handshake:
  - ds_ready_go = !load_use_stall.
  - ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
  - ds_to_es_valid = ds_valid && ds_ready_go.
  - On ds_allowin: ds_valid <= fs_to_ds_valid && !br_taken; ds_inst/ds_pc <= fs_to_ds_bus.
- Reset: ds_valid=0, ds_inst=0, ds_pc=0.
  - Therefore ds_to_es_valid=0, br_bus=0, ds_allowin=1 in the cycle after reset asserts.
  - Reset mid-stall discards the held instruction.
- Decode subset (standard LA32R encodings):
  - 3R: add.w, sub.w, slt, sltu, and, or, nor, xor.
  - Shift-immediate: slli.w, srli.w, srai.w (ui5).
  - addi.w (si12), lu12i.w (si20), ld.w, st.w.
  - Control flow: jirl, b, bl, beq, bne.
  - Any other encoding decodes as NOP: gr_we=0, mem_we=0, no branch, still passed down.
- Sources:
  - rf_raddr1 = rj.
  - rf_raddr2 = rd for beq/bne/st.w, else rk.
  - A source is "used" only if the instruction reads it.
  - Address 0 always yields 0 and is never forwarded or stalled on.
- Forwarding, per source, highest priority first: ES (es_we && dest match && !es_is_load), MS, WS, regfile.
- load_use_stall: ds_valid && es_we && es_is_load && es_dest!=0 && es_dest matches a used source. Held while the stall condition persists.
- Destination:
  - dest = 1 for bl, else rd.
  - gr_we = 0 for st.w, b, beq, bne, NOP; 1 otherwise.
- ALU sources:
  - src1 = pc for jirl/bl, else rj value.
  - src2 = 4 for jirl/bl; sext(si12) for addi/ld/st; ui5 for shifts; {si20,12'b0} for lu12i.w; else rk value.
  - alu_op for lu12i.w = lui (passes src2).
- Branch:
  - br_taken = ds_valid && ds_ready_go && es_allowin && (b | bl | jirl | (beq && rj==rd) | (bne && rj!=rd)), comparing forwarded values.
  - Target = pc + sext(offs16<<2) for beq/bne/jirl-pc-independent forms, except jirl = rj + sext(offs16<<2).
  - b/bl target = pc + sext({offs[9:0],offs[25:10]}<<2).
  - All 32-bit arithmetic wraps modulo 2^32.
- Wrong-path drop: in the cycle br_taken=1, the instruction accepted from fetch is the fall-through; it is latched with ds_valid=0.
- ds_to_es_bus layout, MSB to LSB:
  - alu_op[11:0] one-hot {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  - load_op, mem_we, gr_we, dest[4:0]
  - alu_src1[31:0], alu_src2[31:0], rkd_value[31:0] (store data), pc[31:0]
- Bus contents are don't-care when ds_to_es_valid=0; br_bus is 0 whenever ds_valid=0.

Test Plan:
- Reset held 3 cycles, then released with fs_to_ds_valid=0 -> ds_allowin=1, ds_to_es_valid=0, br_bus=0.
- add.w r3,r1,r2 (0x00100823) at pc 0x1c000000, rf r1=5, r2=7, es/ms/ws_we=0 -> next cycle ds_to_es_valid=1, alu_op=add, src1=5, src2=7, dest=3, gr_we=1.
- Same add.w with es_fwd_bus={1,0,1,0x10}, ms_fwd_bus={1,2,0x20}, ws_fwd_bus={1,1,0x30} -> src1=0x10 (ES beats WS), src2=0x20.
- Load-use: es_fwd_bus={1,1,1,x}, decode add.w r3,r1,r2 -> ds_to_es_valid=0 and ds_allowin=0 for as long as held. Release -> issues with the value forwarded from MS the next cycle.
- beq r1,r2,+8 (0x58000822) at pc 0x1c000010, r1=r2=9 -> br_bus={1,0x1c000018} for one cycle. Fall-through instruction accepted that cycle -> ds_to_es_valid=0 next cycle. With r2=8 -> br_taken=0.
- es_allowin=0 while bl is in decode -> br_taken=0, ds_allowin=0, bus held stable. When es_allowin rises -> br_taken=1, dest=1, src1=pc, src2=4.
